// File: rtl/kbd_fifo4.sv
// kbd_fifo4: 4-entry, 16-bit first-word fall-through FIFO with sticky overflow flag and synchronous flush.
module kbd_fifo4 (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  count,
    output logic        overflow
);
    logic [15:0] mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic        push, pop;
    // Handshakes derive only from count, so neither ready nor valid sees the other side.
    always_comb begin
        in_ready  = count != 3'd4;
        out_valid = count != 3'd0;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        out_data  = out_valid ? mem[rd_ptr] : 16'h0000;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) mem[i] <= 16'h0000;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (push) mem[wr_ptr] <= in_data;
            wr_ptr   <= wr_ptr + {1'b0, push};
            rd_ptr   <= rd_ptr + {1'b0, pop};
            count    <= count + {2'b00, push} - {2'b00, pop};
            overflow <= overflow | (in_valid & ~in_ready);
        end
    end
endmodule

// File: tb/tb_kbd_fifo4.sv
// tb_kbd_fifo4: scoreboard bench for kbd_fifo4; a queue model tracks expected contents, count and overflow.
module tb_kbd_fifo4;
    logic        clk = 1'b0;
    logic        reset, clear, in_valid, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid, overflow;
    logic [15:0] out_data;
    logic [2:0]  count;
    logic [15:0] q[$];
    logic        ovf_m;
    int          checks = 0;
    int          failures = 0;

    kbd_fifo4 dut (
        .clk(clk), .reset(reset), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check outputs against the model, then advance the model across the edge.
    task automatic cycle(input logic iv, input logic [15:0] d, input logic ordy,
                         input logic clr = 1'b0, input logic rst = 1'b0);
        int s;
        in_valid = iv; in_data = d; out_ready = ordy; clear = clr; reset = rst;
        #2;
        s = q.size();
        check("count", {13'd0, count}, 16'(s));
        check("in_ready", {15'd0, in_ready}, {15'd0, s != 4});
        check("out_valid", {15'd0, out_valid}, {15'd0, s != 0});
        check("out_data", out_data, s != 0 ? q[0] : 16'h0000);
        check("overflow", {15'd0, overflow}, {15'd0, ovf_m});
        if (rst || clr) begin
            q.delete();
            ovf_m = 1'b0;
        end else begin
            if (ordy && s > 0) void'(q.pop_front());
            if (iv && s < 4) q.push_back(d);
            if (iv && s == 4) ovf_m = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        ovf_m = 1'b0;
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        @(posedge clk);
        #1;
        cycle(0, 0, 1);
        cycle(1, 16'h0041, 0);
        check("first_word", out_data, 16'h0041);
        check("first_count", {13'd0, count}, 16'd1);
        cycle(0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) cycle(1, 16'(i), 0);
        check("full_ready", {15'd0, in_ready}, 16'd0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1);
        cycle(0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, 16'h0010 + 16'(i), 0);
        cycle(1, 16'h00FF, 1);
        cycle(1, 16'h00FF, 0);
        check("overflow_set", {15'd0, overflow}, 16'd1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1);
        check("overflow_sticky", {15'd0, overflow}, 16'd1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0);
        cycle(1, 16'h0021, 0);
        cycle(1, 16'h0022, 0);
        cycle(1, 16'h0023, 1);
        check("pp_count", {13'd0, count}, 16'd2);
        check("pp_head", out_data, 16'h0022);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1);
        for (int i = 0; i < 10; i++) cycle(1, 16'h0100 + 16'(i), 1);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 16'h0030 + 16'(i), 0);
        cycle(1, 16'h00AA, 0, 1);
        cycle(0, 0, 1);
        check("clear_empty", {15'd0, out_valid}, 16'd0);
        for (int i = 0; i < 4; i++) cycle(1, 16'h0040 + 16'(i), 0);
        cycle(1, 16'h00BB, 1, 1, 1);
        cycle(0, 0, 0);
        check("reset_data", out_data, 16'h0000);
        for (int i = 0; i < 60; i++)
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 19) == 0, 1'b0);
        cycle(0, 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
